rvga_mem_arbiter: RTL and testbench
===================================

// Module: rvga_mem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the core's instruction-fetch and data ports.
//  Sits between rvga_top (imem_*/dmem_* ports) and the memory/bus model.
//  Allows at most one memory transaction in flight. Request fields are registered at grant.
//  Data port has priority, bounded by an instruction-starvation limit.
// PARAMETERS
//  STARVE_LIMIT  4  max consecutive dmem grants while imem is pending; then imem is forced (>=1)
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   reset, asynchronous, active-high
//  imem_r_v_i     in   1   fetch request, level; held until imem_resp_v_o
//  imem_addr_i    in   32  fetch address (rvga_word)
//  imem_data_o    out  32  fetch data, valid with imem_resp_v_o
//  imem_resp_v_o  out  1   one-cycle fetch completion pulse
//  dmem_r_v_i     in   1   load request, level; held until dmem_resp_v_o
//  dmem_w_v_i     in   1   store request, level; held until dmem_resp_v_o
//  dmem_addr_i    in   32  load/store address
//  dmem_data_i    in   32  store data
//  dmem_wmask_i   in   4   store byte mask (rvga_wmask)
//  dmem_data_o    out  32  load data, valid with dmem_resp_v_o
//  dmem_resp_v_o  out  1   one-cycle load/store completion pulse
//  mem_req_v_o    out  1   memory request valid; held until mem_ready_i
//  mem_we_o       out  1   1 = write
//  mem_addr_o     out  32  registered address
//  mem_wdata_o    out  32  registered store data
//  mem_wmask_o    out  4   registered mask; 4'b1111 for reads
//  mem_ready_i    in   1   memory accepts the request this cycle
//  mem_resp_v_i   in   1   read data / write ack; earliest 1 cycle after accept
//  mem_rdata_i    in   32  read data, valid with mem_resp_v_i
// BEHAVIOUR
//  Reset: state=IDLE, starve_cnt=0, every output 0 except mem_wmask_o=4'b1111.
//  FSM states: IDLE, REQ, WAIT.
//   IDLE: if no request, stay in IDLE. Otherwise grant one requester.
//         Capture owner, addr, wdata, wmask and we into registers; next state REQ.
//   REQ:  drive mem_req_v_o=1. On mem_ready_i, go to WAIT; otherwise hold all fields stable.
//   WAIT: on mem_resp_v_i, pulse <owner>_resp_v_o in the same cycle.
//         <owner>_data_o = mem_rdata_i (combinational). Next state IDLE.
//  Grant priority (IDLE only): dmem (r or w) beats imem, unless starve_cnt==STARVE_LIMIT and imem_r_v_i is set.
//  starve_cnt:
//   +1 on each dmem grant while imem_r_v_i=1 (saturates at STARVE_LIMIT).
//   Cleared on any imem grant, and on any dmem grant while imem_r_v_i=0.
//  dmem_r_v_i and dmem_w_v_i both high: treat as a write (we=1). This is illegal input; verification flags it with an assertion.
//  Fetch redirect: the response is squashed if imem_addr_i differs from the latched address, or imem_r_v_i is low, when mem_resp_v_i arrives.
//   Squashed means imem_resp_v_o stays 0 and the memory read completes silently.
//   Next state is IDLE, then a fresh grant.
//  dmem is never squashed; the pipeline is stalled and holds its request.
//  One dead IDLE cycle always follows a completion, so a requester never gets regranted on its stale level request.
//  Latency: request in IDLE at cycle N -> mem_req_v_o at N+1. With ready at N+1 and resp at N+2, resp_v_o is at N+2 (3 cycles).
//  Non-owner resp_v_o is always 0. mem_resp_v_i outside WAIT is ignored.
//  Reset mid-transaction aborts immediately to IDLE. Memory must also be reset; a late mem_resp_v_i is ignored.
// STRUCTURE
//  rvga_types additions:
//   rvga_arb_state_e {ARB_IDLE, ARB_REQ, ARB_WAIT}
//   rvga_mem_owner_e {OWNER_IMEM, OWNER_DMEM}
//   RVGA_WMASK_ALL = 4'b1111
//  Sub-module rvga_arb_req_reg: the load-enabled capture register for addr/wdata/wmask/we/owner, with async reset.
//  FSM, priority logic, starve counter and response steering stay in the top level.
// TESTING
//  Scenario 1, single fetch: imem_r_v_i=1, addr=0x100; memory ready at once, rdata=0x00000013 one cycle later.
//   -> imem_resp_v_o for exactly 1 cycle with data 0x00000013, 3 cycles after the request. mem_we_o=0, mem_wmask_o=4'hF.
//  Scenario 2, collision: imem 0x104 and dmem store at the same time (addr 0x2000, data 0xDEADBEEF, mask 0x3).
//   -> store issued first with we=1 and mask 0x3, dmem_resp_v_o pulses; dead cycle; then fetch of 0x104 issued.
//  Scenario 3, starvation: imem held, STARVE_LIMIT=4, dmem loads back-to-back.
//   -> 4 dmem grants, then the 5th grant goes to imem even though dmem is pending. starve_cnt then reads 0.
//  Scenario 4, back-pressure: mem_ready_i low for 5 cycles during REQ.
//   -> mem_req_v_o/addr/wdata/mask stable all 5 cycles; no resp_v pulse before ready + resp.
//  Scenario 5, redirect: fetch of 0x200 in WAIT, imem_addr_i changes to 0x300 before mem_resp_v_i.
//   -> no imem_resp_v_o for 0x200; next request is issued for 0x300 and returns its data.
//  Scenario 6, reset in REQ/WAIT: assert rst_i asynchronously mid-cycle.
//   -> all outputs 0 (mask 4'hF) immediately; a following mem_resp_v_i is ignored; normal operation resumes after reset.

Source files
------------

// File: rtl/rvga_mem_arbiter_pkg.sv
// rtl/rvga_mem_arbiter_pkg.sv - shared types for the imem/dmem memory arbiter
package rvga_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } rvga_arb_state_e;

    typedef enum logic {
        OWNER_IMEM,
        OWNER_DMEM
    } rvga_mem_owner_e;

    localparam logic [3:0] RVGA_WMASK_ALL = 4'b1111;

    typedef struct packed {
        rvga_mem_owner_e owner;
        logic            we;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [3:0]      wmask;
    } rvga_arb_req_t;

    // Idle-bus value: a read with a full mask, so the reset state looks like a harmless fetch
    localparam rvga_arb_req_t ARB_REQ_RESET = '{
        owner: OWNER_IMEM,
        we:    1'b0,
        addr:  32'h0,
        wdata: 32'h0,
        wmask: RVGA_WMASK_ALL
    };

endpackage

// File: rtl/rvga_arb_req_reg.sv
// rtl/rvga_arb_req_reg.sv - capture register for the granted request fields
module rvga_arb_req_reg
    import rvga_mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  rvga_arb_req_t d,
    output rvga_arb_req_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= ARB_REQ_RESET;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rvga_mem_arbiter.sv
// rtl/rvga_mem_arbiter.sv - one-in-flight arbiter sharing a single-ported memory between fetch and data
module rvga_mem_arbiter
    import rvga_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        imem_r_v_i,
    input  logic [31:0] imem_addr_i,
    output logic [31:0] imem_data_o,
    output logic        imem_resp_v_o,
    input  logic        dmem_r_v_i,
    input  logic        dmem_w_v_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_i,
    input  logic [3:0]  dmem_wmask_i,
    output logic [31:0] dmem_data_o,
    output logic        dmem_resp_v_o,
    output logic        mem_req_v_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_ready_i,
    input  logic        mem_resp_v_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int            CW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    rvga_arb_state_e state, state_next;
    logic [CW-1:0]   starve_cnt, starve_next;
    logic            dead, dead_next;
    logic            load;
    rvga_arb_req_t   req_d, req_q;
    logic            dmem_pend, imem_win, dmem_win, squash, resp_fire;

    assign dmem_pend = dmem_r_v_i | dmem_w_v_i;
    assign imem_win  = imem_r_v_i & (~dmem_pend | (starve_cnt == STARVE_MAX));
    assign dmem_win  = dmem_pend & ~imem_win;

    rvga_arb_req_reg u_req_reg (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (load),
        .d    (req_d),
        .q    (req_q)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
            dead       <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            dead       <= dead_next;
        end
    end

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        dead_next   = dead;
        load        = 1'b0;
        req_d       = ARB_REQ_RESET;

        // Load+store together is illegal; the store wins so memory never sees a half-formed read
        if (dmem_win) begin
            req_d.owner = OWNER_DMEM;
            req_d.we    = dmem_w_v_i;
            req_d.addr  = dmem_addr_i;
            req_d.wdata = dmem_w_v_i ? dmem_data_i : 32'h0;
            req_d.wmask = dmem_w_v_i ? dmem_wmask_i : RVGA_WMASK_ALL;
        end else begin
            req_d.owner = OWNER_IMEM;
            req_d.addr  = imem_addr_i;
        end

        case (state)
            ARB_IDLE: begin
                dead_next = 1'b0;
                // The dead cycle lets a requester drop or change its level request after a completion
                if (!dead && (imem_win || dmem_win)) begin
                    load       = 1'b1;
                    state_next = ARB_REQ;
                    if (dmem_win && imem_r_v_i) begin
                        if (starve_cnt != STARVE_MAX) begin
                            starve_next = starve_cnt + 1'b1;
                        end
                    end else begin
                        starve_next = '0;
                    end
                end
            end
            ARB_REQ: begin
                if (mem_ready_i) begin
                    state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_resp_v_i) begin
                    state_next = ARB_IDLE;
                    dead_next  = 1'b1;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // A redirected or abandoned fetch completes at the memory but is hidden from the core
    assign squash    = ~imem_r_v_i | (imem_addr_i != req_q.addr);
    assign resp_fire = (state == ARB_WAIT) & mem_resp_v_i;

    assign imem_resp_v_o = resp_fire & (req_q.owner == OWNER_IMEM) & ~squash;
    assign dmem_resp_v_o = resp_fire & (req_q.owner == OWNER_DMEM);
    assign imem_data_o   = imem_resp_v_o ? mem_rdata_i : 32'h0;
    assign dmem_data_o   = dmem_resp_v_o ? mem_rdata_i : 32'h0;

    assign mem_req_v_o = (state == ARB_REQ);
    assign mem_we_o    = req_q.we;
    assign mem_addr_o  = req_q.addr;
    assign mem_wdata_o = req_q.wdata;
    assign mem_wmask_o = req_q.wmask;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// tb/tb_rvga_mem_arbiter.sv - scoreboard bench for rvga_mem_arbiter
module tb_rvga_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_r_v, dmem_r_v, dmem_w_v;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic [31:0] imem_data, dmem_data;
    logic        imem_resp_v, dmem_resp_v;
    logic        mem_req_v, mem_we, mem_ready, mem_resp_v;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    rvga_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_r_v_i    (imem_r_v),
        .imem_addr_i   (imem_addr),
        .imem_data_o   (imem_data),
        .imem_resp_v_o (imem_resp_v),
        .dmem_r_v_i    (dmem_r_v),
        .dmem_w_v_i    (dmem_w_v),
        .dmem_addr_i   (dmem_addr),
        .dmem_data_i   (dmem_wdata),
        .dmem_wmask_i  (dmem_wmask),
        .dmem_data_o   (dmem_data),
        .dmem_resp_v_o (dmem_resp_v),
        .mem_req_v_o   (mem_req_v),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_wmask_o   (mem_wmask),
        .mem_ready_i   (mem_ready),
        .mem_resp_v_i  (mem_resp_v),
        .mem_rdata_i   (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } issue_t;

    issue_t      issue_q[$];
    logic [31:0] imem_q[$];
    logic [31:0] dmem_q[$];
    int          checks = 0;
    int          errors = 0;
    int          last_dresp_cyc = 0;
    int          req_rise_cyc = 0;
    int          stall_cfg = 0;
    int          resp_delay_cfg = 0;
    int          inject_cnt = 0;
    logic [31:0] mem_arr [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic issue_t mk_issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] m);
        issue_t e;
        e.we = we; e.addr = a; e.wdata = d; e.wmask = m;
        return e;
    endfunction

    always @(negedge clk) begin
        assert (rst !== 1'b0 || !(dmem_r_v && dmem_w_v))
            else $error("illegal dmem request: load and store asserted together");
    end

    // Memory model: configurable ready stall and response delay, plus an out-of-band response pulse
    initial begin : mem_model
        int          stall_left;
        int          resp_wait;
        int          inject_seen;
        bit          in_req;
        logic [31:0] acc_rdata;
        logic [31:0] v;
        stall_left = 0; resp_wait = -1; inject_seen = 0; in_req = 0; acc_rdata = '0;
        mem_ready = 0; mem_resp_v = 0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_resp_v = 0; mem_rdata = '0; mem_ready = 0;
            if (rst) begin
                resp_wait = -1; in_req = 0; inject_seen = inject_cnt;
            end else begin
                if (resp_wait == 0 || inject_seen != inject_cnt) begin
                    mem_resp_v = 1; mem_rdata = acc_rdata; resp_wait = -1; inject_seen = inject_cnt;
                end else if (resp_wait > 0) begin
                    resp_wait--;
                end
                if (mem_req_v) begin
                    if (!in_req) begin stall_left = stall_cfg; in_req = 1; end
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        mem_ready = 1; in_req = 0; resp_wait = resp_delay_cfg;
                        if (mem_we) begin
                            v = mem_read(mem_addr);
                            for (int b = 0; b < 4; b++)
                                if (mem_wmask[b]) v[8*b +: 8] = mem_wdata[8*b +: 8];
                            mem_arr[mem_addr] = v;
                            acc_rdata = '0;
                        end else begin
                            acc_rdata = mem_read(mem_addr);
                        end
                    end
                end
            end
        end
    end

    task automatic monitor();
        issue_t      e;
        logic [31:0] x;
        bit          req_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_seen = 0;
            end else begin
                if (imem_resp_v) begin
                    checks++;
                    if (imem_q.size() == 0) begin
                        errors++;
                        $display("FAIL imem_resp_unexpected: got pulse data=%h, required no pulse", imem_data);
                    end else begin
                        x = imem_q.pop_front();
                        if (imem_data !== x) begin
                            errors++;
                            $display("FAIL imem_data: got %h, required %h", imem_data, x);
                        end
                    end
                end
                if (dmem_resp_v) begin
                    checks++;
                    last_dresp_cyc = cyc;
                    if (dmem_q.size() == 0) begin
                        errors++;
                        $display("FAIL dmem_resp_unexpected: got pulse data=%h, required no pulse", dmem_data);
                    end else begin
                        x = dmem_q.pop_front();
                        if (dmem_data !== x) begin
                            errors++;
                            $display("FAIL dmem_data: got %h, required %h", dmem_data, x);
                        end
                    end
                end
                if (mem_req_v && !req_seen) req_rise_cyc = cyc;
                req_seen = mem_req_v;
                if (mem_req_v && mem_ready) begin
                    checks++;
                    if (issue_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_issue_unexpected: got addr=%h we=%b, required no request", mem_addr, mem_we);
                    end else begin
                        e = issue_q.pop_front();
                        if (mem_we !== e.we || mem_addr !== e.addr || mem_wmask !== e.wmask ||
                            (e.we && mem_wdata !== e.wdata)) begin
                            errors++;
                            $display("FAIL mem_issue: got we=%b addr=%h wdata=%h mask=%h, required we=%b addr=%h wdata=%h mask=%h",
                                     mem_we, mem_addr, mem_wdata, mem_wmask, e.we, e.addr, e.wdata, e.wmask);
                        end
                    end
                end
            end
        end
    endtask

    // Requester tasks are entered just after a rising edge and hold their level until the response
    task automatic imem_fetch(input logic [31:0] a, output int lat);
        bit got = 0;
        imem_r_v = 1; imem_addr = a;
        imem_q.push_back(mem_read(a));
        lat = -1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (imem_resp_v) begin got = 1; lat = k; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL imem_fetch_timeout: addr=%h got no response in 60 cycles, required a response", a);
        end
        @(posedge clk); #1;
        imem_r_v = 0;
    endtask

    task automatic dmem_access(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bit got = 0;
        dmem_w_v = we; dmem_r_v = !we; dmem_addr = a; dmem_wdata = d; dmem_wmask = m;
        dmem_q.push_back(we ? 32'h0 : mem_read(a));
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (dmem_resp_v) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL dmem_timeout: addr=%h got no response in 60 cycles, required a response", a);
        end
        @(posedge clk); #1;
        dmem_r_v = 0; dmem_w_v = 0;
    endtask

    task automatic test_reset();
        rst = 1; imem_r_v = 0; imem_addr = '0; dmem_r_v = 0; dmem_w_v = 0;
        dmem_addr = '0; dmem_wdata = '0; dmem_wmask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_req_v !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            errors++;
            $display("FAIL reset_mem_outputs: got req=%b we=%b addr=%h wdata=%h, required all 0",
                     mem_req_v, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (mem_wmask !== 4'hF) begin
            errors++;
            $display("FAIL reset_wmask: got %h, required f", mem_wmask);
        end
        checks++;
        if (imem_resp_v !== 0 || dmem_resp_v !== 0 || imem_data !== 0 || dmem_data !== 0) begin
            errors++;
            $display("FAIL reset_core_outputs: got iv=%b dv=%b id=%h dd=%h, required all 0",
                     imem_resp_v, dmem_resp_v, imem_data, dmem_data);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_single_fetch();
        int lat;
        mem_arr[32'h100] = 32'h0000_0013;
        issue_q.push_back(mk_issue(1'b0, 32'h100, 32'h0, 4'hF));
        @(posedge clk); #1;
        imem_fetch(32'h100, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL fetch_latency: got response in cycle %0d, required cycle 3", lat + 1);
        end
        @(negedge clk);
        checks++;
        if (imem_resp_v !== 0) begin
            errors++;
            $display("FAIL fetch_pulse_width: got resp_v=%b in following cycle, required 0", imem_resp_v);
        end
    endtask

    task automatic test_collision();
        int lat;
        issue_q.push_back(mk_issue(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3));
        issue_q.push_back(mk_issue(1'b0, 32'h104, 32'h0, 4'hF));
        @(posedge clk); #1;
        fork
            imem_fetch(32'h104, lat);
            dmem_access(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3);
        join
        checks++;
        if (req_rise_cyc - last_dresp_cyc !== 3) begin
            errors++;
            $display("FAIL collision_dead_cycle: got fetch request %0d cycles after store response, required 3",
                     req_rise_cyc - last_dresp_cyc);
        end
    endtask

    task automatic test_starvation();
        int lat0, lat1;
        for (int i = 0; i < 4; i++) issue_q.push_back(mk_issue(1'b0, 32'(32'h3000 + 4 * i), 32'h0, 4'hF));
        issue_q.push_back(mk_issue(1'b0, 32'h400, 32'h0, 4'hF));
        for (int i = 4; i < 8; i++) issue_q.push_back(mk_issue(1'b0, 32'(32'h3000 + 4 * i), 32'h0, 4'hF));
        issue_q.push_back(mk_issue(1'b0, 32'h404, 32'h0, 4'hF));
        for (int i = 8; i < 10; i++) issue_q.push_back(mk_issue(1'b0, 32'(32'h3000 + 4 * i), 32'h0, 4'hF));
        @(posedge clk); #1;
        fork
            begin
                imem_fetch(32'h400, lat0);
                imem_fetch(32'h404, lat1);
            end
            begin
                for (int i = 0; i < 10; i++) dmem_access(1'b0, 32'(32'h3000 + 4 * i), 32'h0, 4'h0);
            end
        join
    endtask

    task automatic test_back_pressure();
        stall_cfg = 5;
        issue_q.push_back(mk_issue(1'b1, 32'h2100, 32'hCAFE_F00D, 4'hC));
        @(posedge clk); #1;
        fork
            dmem_access(1'b1, 32'h2100, 32'hCAFE_F00D, 4'hC);
            begin
                bit seen = 0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    if (mem_req_v) seen = 1;
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("FAIL bp_req_timeout: got no mem_req_v in 20 cycles, required a request");
                end
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    checks++;
                    if (mem_req_v !== 1 || mem_ready !== 0 || mem_we !== 1 || mem_addr !== 32'h2100 ||
                        mem_wdata !== 32'hCAFE_F00D || mem_wmask !== 4'hC || dmem_resp_v !== 0 || imem_resp_v !== 0) begin
                        errors++;
                        $display("FAIL bp_hold[%0d]: got req=%b rdy=%b we=%b addr=%h wdata=%h mask=%h dv=%b iv=%b, required req=1 rdy=0 we=1 addr=00002100 wdata=cafef00d mask=c dv=0 iv=0",
                                 k, mem_req_v, mem_ready, mem_we, mem_addr, mem_wdata, mem_wmask, dmem_resp_v, imem_resp_v);
                    end
                end
            end
        join
        stall_cfg = 0;
    endtask

    task automatic test_redirect();
        int lat;
        bit acc;
        resp_delay_cfg = 3;
        issue_q.push_back(mk_issue(1'b0, 32'h200, 32'h0, 4'hF));
        issue_q.push_back(mk_issue(1'b0, 32'h300, 32'h0, 4'hF));
        @(posedge clk); #1;
        imem_r_v = 1; imem_addr = 32'h200;
        acc = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (mem_req_v && mem_ready) acc = 1;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL redirect_accept_timeout: got no accept for 200, required one");
        end
        @(posedge clk); #1;
        imem_fetch(32'h300, lat);

        issue_q.push_back(mk_issue(1'b0, 32'h500, 32'h0, 4'hF));
        imem_r_v = 1; imem_addr = 32'h500;
        acc = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (mem_req_v && mem_ready) acc = 1;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL drop_accept_timeout: got no accept for 500, required one");
        end
        @(posedge clk); #1;
        imem_r_v = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (imem_resp_v !== 0) begin
                errors++;
                $display("FAIL drop_squash: got imem_resp_v=%b, required 0", imem_resp_v);
            end
        end
        resp_delay_cfg = 0;
    endtask

    task automatic test_reset_mid();
        int  lat;
        bit  hit;
        stall_cfg = 4;
        @(posedge clk); #1;
        dmem_r_v = 1; dmem_addr = 32'h600;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (mem_req_v) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_req_timeout: got no request, required one");
        end
        #2; rst = 1; #1;
        checks++;
        if (mem_req_v !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_wmask !== 4'hF ||
            imem_resp_v !== 0 || dmem_resp_v !== 0) begin
            errors++;
            $display("FAIL rst_in_req: got req=%b we=%b addr=%h wdata=%h mask=%h iv=%b dv=%b, required 0s with mask f",
                     mem_req_v, mem_we, mem_addr, mem_wdata, mem_wmask, imem_resp_v, dmem_resp_v);
        end
        dmem_r_v = 0; stall_cfg = 0;
        repeat (2) @(posedge clk); #1;
        rst = 0;

        resp_delay_cfg = 4;
        issue_q.push_back(mk_issue(1'b0, 32'h604, 32'h0, 4'hF));
        dmem_r_v = 1; dmem_addr = 32'h604;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (mem_req_v && mem_ready) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_accept_timeout: got no accept for 604, required one");
        end
        @(posedge clk); #3;
        rst = 1; #1;
        checks++;
        if (mem_req_v !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wmask !== 4'hF ||
            imem_resp_v !== 0 || dmem_resp_v !== 0 || dmem_data !== 0) begin
            errors++;
            $display("FAIL rst_in_wait: got req=%b we=%b addr=%h mask=%h iv=%b dv=%b dd=%h, required 0s with mask f",
                     mem_req_v, mem_we, mem_addr, mem_wmask, imem_resp_v, dmem_resp_v, dmem_data);
        end
        dmem_r_v = 0;
        repeat (2) @(posedge clk); #1;
        rst = 0;
        inject_cnt++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (dmem_resp_v !== 0 || imem_resp_v !== 0 || mem_req_v !== 0) begin
                errors++;
                $display("FAIL late_resp: got dv=%b iv=%b req=%b, required all 0", dmem_resp_v, imem_resp_v, mem_req_v);
            end
        end
        resp_delay_cfg = 0;
        issue_q.push_back(mk_issue(1'b0, 32'h700, 32'h0, 4'hF));
        @(posedge clk); #1;
        imem_fetch(32'h700, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL post_reset_latency: got response in cycle %0d, required cycle 3", lat + 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        fork
            monitor();
        join_none
        test_reset();
        test_single_fetch();
        test_collision();
        test_starvation();
        test_back_pressure();
        test_redirect();
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks++;
        if (issue_q.size() !== 0) begin
            errors++;
            $display("FAIL issue_queue_drain: got %0d outstanding, required 0", issue_q.size());
        end
        checks++;
        if (imem_q.size() !== 0) begin
            errors++;
            $display("FAIL imem_queue_drain: got %0d outstanding, required 0", imem_q.size());
        end
        checks++;
        if (dmem_q.size() !== 0) begin
            errors++;
            $display("FAIL dmem_queue_drain: got %0d outstanding, required 0", dmem_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
